// File: rtl/conv3x3_seq_if.sv
// SRAM port bundle between the convolution sequencer and the IFM, weight and result RAMs.
// master = sequencer side; slave = RAM side.
interface conv3x3_seq_if #(
  parameter int AW = 13
);
  logic          ifm_cs;
  logic [AW-1:0] ifm_addr;
  logic [31:0]   ifm_dout;
  logic          wht_cs;
  logic [AW-1:0] wht_addr;
  logic [31:0]   wht_dout;
  logic          res_cs;
  logic          res_we;
  logic [3:0]    res_wem;
  logic [AW-1:0] res_addr;
  logic [31:0]   res_din;

  modport master (
    output ifm_cs, ifm_addr, input ifm_dout,
    output wht_cs, wht_addr, input wht_dout,
    output res_cs, res_we, res_wem, res_addr, res_din
  );

  modport slave (
    input ifm_cs, ifm_addr, output ifm_dout,
    input wht_cs, wht_addr, output wht_dout,
    input res_cs, res_we, res_wem, res_addr, res_din
  );
endinterface

// File: rtl/conv3x3_seq.sv
// 3x3 valid-padding, stride-1 convolution sequencer: loads the kernel, walks the IFM,
// accumulates int8 products into 32-bit sums and writes one result word per output pixel.
module conv3x3_seq #(
  parameter int IFM_W = 16,
  parameter int IFM_H = 16,
  parameter int AW    = 13
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          relu_en,
  output logic          busy,
  output logic          done,
  conv3x3_seq_if.master mem
);
  localparam int OW = IFM_W - 2;
  localparam int OH = IFM_H - 2;
  localparam int XW = $clog2(IFM_W);
  localparam int YW = $clog2(IFM_H);

  typedef enum logic [2:0] {IDLE, LDW, CONV, WR, FIN} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic [XW-1:0]     ox;
  logic [YW-1:0]     oy;
  logic [AW-1:0]     base;
  logic [AW-1:0]     pix_idx;
  logic              relu;
  logic signed [7:0] w [0:8];
  logic signed [31:0] acc;

  logic signed [7:0]  pix;
  logic signed [7:0]  wsel;
  logic signed [15:0] prod;
  logic signed [31:0] next_acc;
  logic               last_x;
  logic               last_y;
  logic [AW-1:0]      next_base;
  logic               unused_bits;

  // Word offset of kernel tap k from the window's top-left pixel.
  function automatic logic [AW-1:0] koff(input logic [3:0] k);
    int unsigned kk;
    kk = 32'(k);
    return AW'((kk / 3) * IFM_W + (kk % 3));
  endfunction

  always_comb begin
    pix  = signed'(mem.ifm_dout[7:0]);
    wsel = '0;
    if (cnt >= 4'd1 && cnt <= 4'd9) wsel = w[cnt - 4'd1];
    prod      = 16'(pix) * 16'(wsel);
    next_acc  = ((cnt == 4'd1) ? 32'sd0 : acc) + 32'(prod);
    last_x    = (ox == XW'(OW - 1));
    last_y    = (oy == YW'(OH - 1));
    // Row wrap skips the two border columns that have no full window.
    next_base = last_x ? base + AW'(3) : base + AW'(1);
    unused_bits = ^{mem.ifm_dout[31:8], mem.wht_dout[31:8]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      ox           <= '0;
      oy           <= '0;
      base         <= '0;
      pix_idx      <= '0;
      relu         <= 1'b0;
      acc          <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      mem.ifm_cs   <= 1'b0;
      mem.ifm_addr <= '0;
      mem.wht_cs   <= 1'b0;
      mem.wht_addr <= '0;
      mem.res_cs   <= 1'b0;
      mem.res_we   <= 1'b0;
      mem.res_wem  <= '0;
      mem.res_addr <= '0;
      mem.res_din  <= '0;
      for (int unsigned i = 0; i < 9; i++) w[i] <= '0;
    end else begin
      mem.ifm_cs   <= 1'b0;
      mem.ifm_addr <= '0;
      mem.wht_cs   <= 1'b0;
      mem.wht_addr <= '0;
      mem.res_cs   <= 1'b0;
      mem.res_we   <= 1'b0;
      mem.res_wem  <= '0;
      mem.res_addr <= '0;
      mem.res_din  <= '0;
      done         <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            state        <= LDW;
            busy         <= 1'b1;
            relu         <= relu_en;
            cnt          <= '0;
            ox           <= '0;
            oy           <= '0;
            base         <= '0;
            pix_idx      <= '0;
            mem.wht_cs   <= 1'b1;
            mem.wht_addr <= '0;
          end
        end

        LDW: begin
          if (cnt != 4'd0) w[cnt - 4'd1] <= signed'(mem.wht_dout[7:0]);
          if (cnt < 4'd8) begin
            mem.wht_cs   <= 1'b1;
            mem.wht_addr <= AW'(cnt) + AW'(1);
          end
          if (cnt == 4'd9) begin
            state        <= CONV;
            cnt          <= '0;
            mem.ifm_cs   <= 1'b1;
            mem.ifm_addr <= base;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end

        CONV: begin
          if (cnt != 4'd0) acc <= next_acc;
          if (cnt < 4'd8) begin
            mem.ifm_cs   <= 1'b1;
            mem.ifm_addr <= base + koff(cnt + 4'd1);
          end
          if (cnt == 4'd9) begin
            state        <= WR;
            mem.res_cs   <= 1'b1;
            mem.res_we   <= 1'b1;
            mem.res_wem  <= 4'hF;
            mem.res_addr <= pix_idx;
            mem.res_din  <= (relu && next_acc[31]) ? '0 : next_acc;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end

        WR: begin
          pix_idx <= pix_idx + AW'(1);
          cnt     <= '0;
          if (last_x && last_y) begin
            state <= FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state        <= CONV;
            base         <= next_base;
            ox           <= last_x ? '0 : ox + XW'(1);
            oy           <= last_x ? oy + YW'(1) : oy;
            mem.ifm_cs   <= 1'b1;
            mem.ifm_addr <= next_base;
          end
        end

        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/conv3x3_seq.md
Name: conv3x3_seq

Overview:
- Convolution sequencer directly downstream of the accelerator's ICB front end.
- After firmware fills the IFM and weight SRAMs and writes CTRL.start, this block:
  - reads the 3x3 kernel into registers;
  - slides the kernel over the single-channel IFM (valid padding, stride 1);
  - accumulates 9 int8 products per output pixel;
  - applies optional ReLU and writes one 32-bit result per word into the result SRAM.
- It drives all three SRAM ports only while busy; the front end owns them otherwise.

Parameters:
- IFM_W, 16, input feature-map width in pixels (>=3)
- IFM_H, 16, input feature-map height in pixels (>=3)
- AW, 13, SRAM word-address width (8192-deep RAMs)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- start  in  1  one-cycle start pulse (CTRL bit 0)
- relu_en  in  1  ReLU enable; sampled on the accepted start
- busy  out  1  high while a run is in progress
- done  out  1  one-cycle pulse at end of run (sets STATUS)
- ifm_cs  out  1  IFM SRAM chip select (read only)
- ifm_addr  out  AW  IFM SRAM word address
- ifm_dout  in  32  IFM read data; [7:0] = signed int8 pixel, 1-cycle latency
- wht_cs  out  1  weight SRAM chip select (read only)
- wht_addr  out  AW  weight SRAM word address
- wht_dout  in  32  weight read data; [7:0] = signed int8, 1-cycle latency
- res_cs  out  1  result SRAM chip select
- res_we  out  1  result SRAM write enable
- res_wem  out  4  result write byte mask; 4'hF whenever res_we
- res_addr  out  AW  result SRAM word address
- res_din  out  32  result write data

Behaviour:
- Reset: all outputs 0 (busy, done, cs/we, addresses, res_din, res_wem); FSM to IDLE; accumulator and weight registers cleared.
- Reset priority:
  - rst wins over start in the same cycle.
  - rst mid-run aborts: every cs is low the cycle after rst; no partial writes.
- SRAM timing: address and cs issued in cycle t; dout valid in cycle t+1.
- FSM states: IDLE, LDW, CONV, WR, FIN.
- IDLE:
  - start=1 -> LDW; busy goes high the next cycle; relu_en latched.
  - start while busy is ignored.
- LDW: 10 cycles.
  - Cycles 0..8 issue wht_addr 0..8 with wht_cs=1.
  - Cycles 1..9 capture w[k] = wht_dout[7:0].
  - Then -> CONV with ox=oy=0.
- CONV: 10 cycles per output pixel.
  - Cycles 0..8 issue ifm_addr = (oy+ky)*IFM_W + (ox+kx), with kx fastest and k = ky*3+kx, ifm_cs=1.
  - Cycles 1..9 accumulate: acc <= (first ? 0 : acc) + sext32(pix*w[k]). The product is a 16-bit signed multiply.
  - Then -> WR.
- WR: 1 cycle.
  - res_cs=res_we=1, res_wem=4'hF.
  - res_addr = oy*(IFM_W-2) + ox.
  - res_din = (relu && acc[31]) ? 0 : acc.
  - Advance: ox increments; it wraps at IFM_W-2 and increments oy.
  - If the last pixel was written (ox=IFM_W-3, oy=IFM_H-3) -> FIN, else -> CONV.
- FIN: done=1 for one cycle, busy=0 in the same cycle; -> IDLE.
- Arithmetic:
  - The accumulator is 32-bit signed.
  - Maximum magnitude is 9*16384 = 147456, so no overflow or saturation is required.
- Cycle count: a run is 10 + 11*(IFM_W-2)*(IFM_H-2) cycles from the first LDW cycle, plus 1 FIN cycle. With defaults: 10 + 2156 + 1 = 2167 cycles.
- Address order: result addresses are written strictly increasing 0..(IFM_W-2)*(IFM_H-2)-1; no address is written twice.
- Idle outputs: cs outputs are 0 in every cycle not listed above.

Test Plan:
- All-ones test: IFM all 0x01, weights all 0x01, relu_en=0, defaults -> 196 writes, addr 0..195, each res_din = 32'h9; done pulses exactly 2167 cycles after the start cycle.
- Identity test: weight w[4]=1, others 0, IFM word a holds a[7:0] as signed -> res[oy*14+ox] = sext(IFM[(oy+1)*16+ox+1]); spot-check addr 0 = IFM[17] and addr 195 = IFM[238].
- ReLU test: IFM all 0x01, weights all 0xFF (-1). relu_en=0 -> all results 32'hFFFFFFF7. Repeat with relu_en=1 -> all results 0.
- Extreme values: IFM all 0x80, weights all 0x80 -> every result 32'h00024000 (147456); no wrap.
- Start during busy: a second start pulse 50 cycles into a run -> no restart, write count still 196, single done pulse.
- Reset mid-run: rst asserted for 1 cycle during CONV at pixel 20 -> next cycle busy=0 and all cs=0. A fresh start then performs LDW from wht_addr 0 and rewrites from res_addr 0.
